// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped branch predictor: combinational lookup on the Fetch PC,
// misprediction detection and table training from the Execute-stage resolution.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] f_pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_SNT   = 2'b00;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_BITS-1:0] w_f_tag;
  logic                w_f_hit;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0] w_ex_tag;
  logic                w_ex_hit;
  logic                w_is_ctrl;
  logic                w_is_jal;
  logic [31:0]         w_ex_pc4;
  logic                w_train;
  logic                w_stale;
  logic [1:0]          w_ctr_cur;
  logic [1:0]          w_ctr_inc;
  logic [1:0]          w_ctr_dec;

  assign w_f_idx  = f_pc[IDX_BITS+1:2];
  assign w_f_tag  = f_pc[31:IDX_BITS+2];
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
  assign w_ex_tag = ex_pc[31:IDX_BITS+2];
  assign w_ex_pc4 = ex_pc + 32'd4;

  // Fetch lookup: zero-latency prediction from the current table contents.
  always_comb begin
    w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    f_pred_taken  = 1'b0;
    f_pred_target = f_pc + 32'd4;
    if (w_f_hit && r_ctr[w_f_idx][1]) begin
      f_pred_taken  = 1'b1;
      f_pred_target = r_target[w_f_idx];
    end else begin
      f_pred_taken  = 1'b0;
    end
  end

  // Execute resolution: misprediction, redirect and which kind of table update applies.
  always_comb begin
    w_is_jal    = (ex_opcode == OP_JAL);
    w_is_ctrl   = (ex_opcode == OP_BRANCH) || w_is_jal;
    w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    mispredict  = 1'b0;
    redirect_pc = w_ex_pc4;
    w_train     = 1'b0;
    w_stale     = 1'b0;
    if (ex_valid) begin
      if (w_is_ctrl) begin
        w_train     = 1'b1;
        mispredict  = (ex_br_taken != ex_pred_taken) ||
                      (ex_br_taken && (ex_target != ex_pred_target));
        redirect_pc = ex_br_taken ? ex_target : w_ex_pc4;
      end else if (ex_pred_taken) begin
        // A non-control instruction was predicted taken: the entry is stale.
        mispredict = 1'b1;
        w_stale    = 1'b1;
      end else begin
        mispredict = 1'b0;
      end
    end else begin
      mispredict = 1'b0;
    end
  end

  // Saturating counter neighbours of the entry being trained.
  always_comb begin
    w_ctr_cur = r_ctr[w_ex_idx];
    if (w_ctr_cur == CTR_ST) begin
      w_ctr_inc = CTR_ST;
    end else begin
      w_ctr_inc = w_ctr_cur + 2'd1;
    end
    if (w_ctr_cur == CTR_SNT) begin
      w_ctr_dec = CTR_SNT;
    end else begin
      w_ctr_dec = w_ctr_cur - 2'd1;
    end
  end

  // Table state: reset, training on control instructions, invalidation of stale entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else begin
      if (w_train) begin
        if (w_ex_hit) begin
          if (ex_br_taken) begin
            r_ctr[w_ex_idx]    <= w_ctr_inc;
            r_target[w_ex_idx] <= ex_target;
          end else begin
            r_ctr[w_ex_idx] <= w_ctr_dec;
          end
        end else if (ex_br_taken) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= ex_target;
          r_ctr[w_ex_idx]    <= w_is_jal ? CTR_ST : CTR_WT;
        end else begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx];
        end
      end else if (w_stale) begin
        r_valid[w_ex_idx] <= 1'b0;
      end else begin
        r_valid[w_ex_idx] <= r_valid[w_ex_idx];
      end
    end
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count <= 32'd0;
      mp_count <= 32'd0;
    end else begin
      if (w_train) begin
        br_count <= br_count + 32'd1;
      end else begin
        br_count <= br_count;
      end
      if (mispredict) begin
        mp_count <= mp_count + 32'd1;
      end else begin
        mp_count <= mp_count;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_opcode;
  logic        ex_br_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int n_chk;
  int n_fail;

  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ADDI = 7'b0010011;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_br_taken(ex_br_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_tgt);
    f_pc = pc;
    #1;
    chk({tag, ".taken"}, {31'd0, f_pred_taken}, {31'd0, exp_tk});
    chk({tag, ".target"}, f_pred_target, exp_tgt);
  endtask

  task automatic cnt(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mp);
    chk({tag, ".br_count"}, br_count, exp_br);
    chk({tag, ".mp_count"}, mp_count, exp_mp);
  endtask

  // One Execute-stage resolution: check the combinational outcome, then commit on the edge.
  task automatic resolve(input string tag, input logic vld, input logic [31:0] pc,
                         input logic [6:0] op, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic exp_mp, input logic [31:0] exp_rd);
    ex_valid = vld; ex_pc = pc; ex_opcode = op; ex_br_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #2;
    chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
    if (vld) chk({tag, ".redirect"}, redirect_pc, exp_rd);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; f_pc = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0; ex_opcode = 7'd0;
    ex_br_taken = 1'b0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    look("reset", 32'h100, 1'b0, 32'h104);
    cnt("reset", 32'd0, 32'd0);

    // Cold taken branch allocates with weak-taken.
    resolve("cold", 1'b1, 32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    look("cold", 32'h100, 1'b1, 32'h80);
    cnt("cold", 32'd1, 32'd1);

    // Hysteresis: 10 -> 01 -> 10 -> 11 -> 10.
    resolve("hys_nt", 1'b1, 32'h100, BEQ, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    look("hys_nt", 32'h100, 1'b0, 32'h104);
    resolve("hys_t1", 1'b1, 32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    look("hys_t1", 32'h100, 1'b1, 32'h80);
    resolve("hys_t2", 1'b1, 32'h100, BEQ, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
    resolve("hys_nt2", 1'b1, 32'h100, BEQ, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    look("hys_nt2", 32'h100, 1'b1, 32'h80);
    cnt("hys", 32'd5, 32'd4);

    // Saturation at strong-taken, then walk down to strong-not-taken.
    for (int i = 0; i < 5; i++)
      resolve("sat_t", 1'b1, 32'h100, BEQ, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
    look("sat_t", 32'h100, 1'b1, 32'h80);
    resolve("sat_n1", 1'b1, 32'h100, BEQ, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    resolve("sat_n2", 1'b1, 32'h100, BEQ, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    for (int i = 0; i < 3; i++)
      resolve("sat_n", 1'b1, 32'h100, BEQ, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104);
    look("sat_n", 32'h100, 1'b0, 32'h104);
    cnt("sat", 32'd15, 32'd6);
    // Still a hit at 00: one taken moves to 01 (not-taken), new target stored.
    resolve("sat_up1", 1'b1, 32'h100, BEQ, 1'b1, 32'h90, 1'b0, 32'h104, 1'b1, 32'h90);
    look("sat_up1", 32'h100, 1'b0, 32'h104);
    resolve("sat_up2", 1'b1, 32'h100, BEQ, 1'b1, 32'h90, 1'b0, 32'h104, 1'b1, 32'h90);
    look("sat_up2", 32'h100, 1'b1, 32'h90);
    cnt("sat_up", 32'd17, 32'd8);

    // Stale entry: 0x200 shares index 0 and replaces the 0x100 entry.
    resolve("alloc200", 1'b1, 32'h200, BEQ, 1'b1, 32'h40, 1'b0, 32'h204, 1'b1, 32'h40);
    look("alloc200", 32'h200, 1'b1, 32'h40);
    look("evict100", 32'h100, 1'b0, 32'h104);
    resolve("stale", 1'b1, 32'h200, ADDI, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h204);
    look("stale", 32'h200, 1'b0, 32'h204);
    resolve("jalr", 1'b1, 32'h240, JALR, 1'b1, 32'h800, 1'b0, 32'h244, 1'b0, 32'h244);
    cnt("stale", 32'd18, 32'd10);

    // JAL allocates strong-taken: one not-taken still predicts taken.
    resolve("jal", 1'b1, 32'h300, JAL, 1'b1, 32'h500, 1'b0, 32'h304, 1'b1, 32'h500);
    look("jal", 32'h300, 1'b1, 32'h500);
    resolve("jal_nt", 1'b1, 32'h300, JAL, 1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 32'h304);
    look("jal_nt", 32'h300, 1'b1, 32'h500);
    cnt("jal", 32'd20, 32'd12);

    // Gated: nothing changes with ex_valid low.
    resolve("gate", 1'b0, 32'h300, BEQ, 1'b0, 32'h999, 1'b1, 32'h500, 1'b0, 32'h0);
    look("gate", 32'h300, 1'b1, 32'h500);
    cnt("gate", 32'd20, 32'd12);

    // Same-cycle lookup sees pre-update contents.
    f_pc = 32'h300;
    ex_valid = 1'b1; ex_pc = 32'h300; ex_opcode = JAL; ex_br_taken = 1'b1;
    ex_target = 32'h700; ex_pred_taken = 1'b1; ex_pred_target = 32'h500;
    #2;
    chk("conc.mispredict", {31'd0, mispredict}, 32'd1);
    chk("conc.redirect", redirect_pc, 32'h700);
    chk("conc.old_target", f_pred_target, 32'h500);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    look("conc.new", 32'h300, 1'b1, 32'h700);
    cnt("conc", 32'd21, 32'd13);

    // Reset dominates a concurrent update.
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_pc = 32'h340; ex_opcode = BEQ; ex_br_taken = 1'b1;
    ex_target = 32'h60; ex_pred_taken = 1'b0; ex_pred_target = 32'h344;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    rst_n = 1'b1;
    look("rst_mid.340", 32'h340, 1'b0, 32'h344);
    look("rst_mid.300", 32'h300, 1'b0, 32'h304);
    cnt("rst_mid", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side dynamic branch predictor for the 5-stage RV32I pipeline. In Fetch, a combinational lookup of the current PC produces a predicted next-PC. In Execute, it consumes the resolved outcome from the branch condition unit (`br_taken`), detects mispredictions, drives the flush/redirect, and trains a direct-mapped table. Each table entry holds a tag, a target and a 2-bit saturating counter. It sits between the PC mux and the Execute-stage branch resolution.

## Interface
Parameters:
- `IDX_BITS`, 4: table index width; entries = 2^IDX_BITS, index = `pc[IDX_BITS+1:2]`.
- `TAG_BITS`, 30-IDX_BITS: tag = `pc[31:IDX_BITS+2]`. A full tag gives no aliasing.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `f_pc`  in  32  Fetch-stage PC.
- `f_pred_taken`  out  1  hit and `ctr[1]`=1.
- `f_pred_target`  out  32  stored target on a predicted-taken hit, else `f_pc+4`.
- `ex_valid`  in  1  Execute holds a real (non-bubble, non-stalled) instruction.
- `ex_pc`  in  32  Execute-stage PC.
- `ex_opcode`  in  7  Execute-stage opcode.
- `ex_br_taken`  in  1  resolved outcome from the branch condition unit (1 for JAL).
- `ex_target`  in  32  computed branch/JAL target.
- `ex_pred_taken`  in  1  `f_pred_taken`, piped with the instruction.
- `ex_pred_target`  in  32  `f_pred_target`, piped with the instruction.
- `mispredict`  out  1  flush IF/ID and ID/EX, load `redirect_pc`.
- `redirect_pc`  out  32  correct next PC.
- `br_count`  out  32  resolved branch/JAL count.
- `mp_count`  out  32  misprediction count.

## Operation
Entry state:
- Each entry holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Lookup:
- Purely combinational from `f_pc`.
- Hit = `valid && tag match`.

Resolution (all gated by `ex_valid`; if `ex_valid`=0, `mispredict`=0 and no state changes):
- **Control instruction** (`ex_opcode` = 1100011 or 1101111):
  - `mispredict = (ex_br_taken != ex_pred_taken) || (ex_br_taken && ex_target != ex_pred_target)`.
  - `redirect_pc` = `ex_target` if `ex_br_taken`, else `ex_pc+4`.
- **Other opcode with `ex_pred_taken`=1** (stale entry):
  - `mispredict`=1, `redirect_pc`=`ex_pc+4`.
  - Entry at `ex_pc` index is invalidated.
- **Other opcode with `ex_pred_taken`=0**: `mispredict`=0, no update.
- **JALR** (1100111) is not predicted here; it falls under the two "other opcode" rules above.

Training (registered, at the `clk` edge with `ex_valid`=1, control instruction only):
- Hit, taken: `ctr` saturating +1 (11 stays 11); `target` <= `ex_target`.
- Hit, not taken: `ctr` saturating -1 (00 stays 00); `target` unchanged.
- Miss, taken: allocate and overwrite the entry: `valid`=1, tag, `target`; `ctr`=10 for a branch, 11 for JAL.
- Miss, not taken: no allocation.

Counters:
- `br_count` += 1 per resolved control instruction.
- `mp_count` += 1 per `mispredict`.
- Both wrap modulo 2^32.

## Timing
Combinational paths:
- Lookup has zero-cycle latency: `f_pred_*` depend combinationally on `f_pc`.
- `mispredict` and `redirect_pc` are combinational from the Execute inputs in the same cycle. The pipeline flushes on the following edge (2-instruction penalty).

Registered updates:
- Table and counter updates become visible the cycle after resolution.
- No bypass: a same-cycle lookup at the index being updated returns the old contents.

Reset:
- `rst_n`=0 sampled at a rising edge: all `valid`=0, all `ctr`=01, `target`/`tag` don't-care, `br_count`=`mp_count`=0.
- Reset dominates any concurrent update. Reset asserted mid-training discards that update.

Outputs while held in reset:
- `f_pred_taken`=0 and `f_pred_target`=`f_pc+4` (valid bits cleared after the first reset edge).
- `mispredict` still follows its combinational equation. The core must hold `ex_valid`=0 during reset.

## Test plan
1. **Reset:** hold `rst_n`=0 one cycle, then `f_pc`=0x100 -> `f_pred_taken`=0, `f_pred_target`=0x104, both counters 0.
2. **Cold taken branch:** BEQ at 0x100, `ex_br_taken`=1, `ex_target`=0x80, pred=0.
   - Same cycle: `mispredict`=1, `redirect_pc`=0x80.
   - Next cycle: `f_pc`=0x100 gives `f_pred_taken`=1, target 0x80, ctr=10.
3. **Hysteresis:** from ctr=10, resolve not-taken.
   - Result: `mispredict`=1, `redirect_pc`=0x104, ctr=01, predicts NT.
   - Two more taken resolutions: ctr 10, then 11.
   - Then one not-taken: ctr=10, still predicts taken.
4. **Saturation:** 5 taken resolutions -> ctr stays 11. 5 not-taken resolutions -> ctr stays 00, entry still valid.
5. **Stale entry and JAL:**
   - Entry at 0x200 valid; resolve ADDI (0010011) at 0x200 with `ex_pred_taken`=1 -> `mispredict`=1, redirect 0x204, entry invalidated.
   - JAL at 0x300 -> allocates with ctr=11.
6. **Gating and concurrency:**
   - `ex_valid`=0 with mismatching inputs -> `mispredict`=0, no table or counter change.
   - Lookup and update at the same index in one cycle -> lookup returns the pre-update value.
